// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the matrix keypad scanner.
// Imported by the scanner top and by the per-key debounce cell.
package keypad_pkg;

    typedef enum logic [1:0] {
        DRIVE,
        SETTLE,
        SAMPLE
    } scan_state_t;

    function automatic int code_width(input int rows, input int cols);
        int w;
        w = $clog2(rows * cols);
        return (w < 1) ? 1 : w;
    endfunction

    // Never below 3 so the row synchronizer has flushed before sampling.
    function automatic int settle_cycles(input int settle_ns, input int period_ns);
        int n;
        n = settle_ns / period_ns;
        return (n < 3) ? 3 : n;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int stable_scans);
        int w;
        w = $clog2(stable_scans + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/keypad_key_cell.sv
// One debounced key: stored state plus a run counter of differing scans.
// Emits when the run reaches StableScans; holds completely while stalled.
module keypad_key_cell
    import keypad_pkg::*;
#(
    parameter int StableScans = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic stall_i,
    input  logic s_i,
    output logic emit_o
);

    localparam int CntW = cnt_width(StableScans);
    localparam logic [CntW-1:0] CntMax = CntW'(StableScans - 1);

    logic            st_q;
    logic            st_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            differ;
    logic            at_max;

    assign differ = (s_i != st_q);
    assign at_max = (cnt_q == CntMax);
    assign emit_o = en_i && differ && at_max;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (en_i && !stall_i) begin
            if (!differ) begin
                cnt_d = '0;
            end else if (at_max) begin
                st_d  = s_i;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes columns, waits for settling, samples rows
// and reports debounced press/release events over a valid/ready handshake.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int Rows           = 4,
    parameter int Cols           = 4,
    parameter int ClockPeriod_ns = 20,
    parameter int SettleTime_ns  = 10_000,
    parameter int StableScans    = 3,
    localparam int KeyCodeWidth  = code_width(Rows, Cols)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [Rows-1:0]         row_i,
    output logic [Cols-1:0]         col_o,
    output logic                    key_valid_o,
    output logic [KeyCodeWidth-1:0] key_code_o,
    output logic                    key_pressed_o,
    input  logic                    key_ready_i
);

    localparam int Keys         = Rows * Cols;
    localparam int SettleCycles = settle_cycles(SettleTime_ns, ClockPeriod_ns);
    localparam int SetW         = $clog2(SettleCycles + 1);
    localparam int RowW         = idx_width(Rows);
    localparam int ColW         = idx_width(Cols);

    logic [Rows-1:0]         row_meta_q;
    logic [Rows-1:0]         row_sync_q;
    scan_state_t             state_q;
    scan_state_t             state_d;
    logic [RowW-1:0]         r_q;
    logic [RowW-1:0]         r_d;
    logic [ColW-1:0]         c_q;
    logic [ColW-1:0]         c_d;
    logic [SetW-1:0]         settle_q;
    logic [SetW-1:0]         settle_d;
    logic [Cols-1:0]         col_q;
    logic [Cols-1:0]         col_d;
    logic                    valid_q;
    logic                    valid_d;
    logic [KeyCodeWidth-1:0] code_q;
    logic [KeyCodeWidth-1:0] code_d;
    logic                    pressed_q;
    logic                    pressed_d;

    logic [Keys-1:0]         emit;
    logic                    emit_any;
    logic                    stall;
    logic                    load;
    logic                    s_cur;
    logic [KeyCodeWidth-1:0] cur_code;

    assign emit_any = |emit;
    assign stall    = emit_any && valid_q && !key_ready_i;
    assign load     = emit_any && !stall;
    assign s_cur    = ~row_sync_q[r_q];
    assign cur_code = KeyCodeWidth'(int'(c_q) * Rows + int'(r_q));

    for (genvar ci = 0; ci < Cols; ci++) begin : g_col
        for (genvar ri = 0; ri < Rows; ri++) begin : g_row
            logic en;
            assign en = (state_q == SAMPLE)
                     && (c_q == ColW'(ci))
                     && (r_q == RowW'(ri));

            keypad_key_cell #(
                .StableScans (StableScans)
            ) u_cell (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .en_i    (en),
                .stall_i (stall),
                .s_i     (~row_sync_q[ri]),
                .emit_o  (emit[ci*Rows+ri])
            );
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        settle_d  = settle_q;
        col_d     = col_q;
        valid_d   = valid_q;
        code_d    = code_q;
        pressed_d = pressed_q;

        // A new load wins over clearing, so accepted events chain without gaps.
        if (load) begin
            valid_d   = 1'b1;
            code_d    = cur_code;
            pressed_d = s_cur;
        end else if (valid_q && key_ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            DRIVE: begin
                col_d    = ~(Cols'(1) << c_q);
                settle_d = SetW'(SettleCycles - 1);
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    r_d     = '0;
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            SAMPLE: begin
                if (!stall) begin
                    if (r_q == RowW'(Rows - 1)) begin
                        c_d     = (c_q == ColW'(Cols - 1)) ? '0 : c_q + ColW'(1);
                        state_d = DRIVE;
                    end else begin
                        r_d = r_q + RowW'(1);
                    end
                end
            end
            default: state_d = DRIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            state_q    <= DRIVE;
            r_q        <= '0;
            c_q        <= '0;
            settle_q   <= '0;
            col_q      <= '1;
            valid_q    <= 1'b0;
            code_q     <= '0;
            pressed_q  <= 1'b0;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            settle_q   <= settle_d;
            col_q      <= col_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            pressed_q  <= pressed_d;
        end
    end

    assign col_o         = col_q;
    assign key_valid_o   = valid_q;
    assign key_code_o    = code_q;
    assign key_pressed_o = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a per-scan key model predicts events,
// a monitor pops and compares them at every accepted handshake.
module tb_keypad_scanner;

    localparam int NK     = 16;
    localparam int STABLE = 3;

    typedef struct {
        int code;
        bit pressed;
    } ev_t;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic       valid;
    logic [3:0] code;
    logic       pressed;
    logic       ready;

    keypad_scanner #(
        .Rows           (4),
        .Cols           (4),
        .ClockPeriod_ns (20),
        .SettleTime_ns  (100),
        .StableScans    (STABLE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .row_i         (row),
        .col_o         (col),
        .key_valid_o   (valid),
        .key_code_o    (code),
        .key_pressed_o (pressed),
        .key_ready_i   (ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] phys = '0;
    logic [15:0] phys_next = '0;
    int          rdy_mode = 0;

    bit  mst [NK];
    int  mcnt[NK];
    ev_t exp_q[$];
    int  scan_cnt = 0;
    int  bnd_cyc = 0;
    logic [3:0] prev_col = 4'hf;
    int  acc_cyc[NK];

    bit       held = 0;
    bit [3:0] h_code;
    bit       h_pr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Physical matrix: a closed key pulls its row low while its column is driven.
    always_comb begin
        row = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && phys[c*4+r]) row[r] = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: ready = 1'b1;
            1: ready = 1'b0;
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One full scan: every key sees one sample, in ascending key order.
    task automatic model_scan();
        for (int k = 0; k < NK; k++) begin
            bit s;
            s = phys[k];
            if (s == mst[k]) begin
                mcnt[k] = 0;
            end else if (mcnt[k] == STABLE - 1) begin
                ev_t e;
                mst[k]    = s;
                mcnt[k]   = 0;
                e.code    = k;
                e.pressed = s;
                exp_q.push_back(e);
            end else begin
                mcnt[k]++;
            end
        end
    endtask

    // A scan starts when column 0 becomes driven; key inputs change only here.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                mst[k]  = 0;
                mcnt[k] = 0;
            end
            exp_q.delete();
        end else if (col == 4'b1110 && prev_col != 4'b1110) begin
            phys    = phys_next;
            bnd_cyc = cyc;
            model_scan();
            scan_cnt++;
        end
        prev_col = col;
    end

    always @(negedge clk) begin
        chk($countones(~col) <= 1, "col_onehot", int'(col), 0);
        if (rst) begin
            held = 0;
        end else if (valid) begin
            if (held) begin
                chk(code == h_code && pressed == h_pr, "hold_stable",
                    int'({code, pressed}), int'({h_code, h_pr}));
            end
            if (ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_event", int'(code), -1);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk(int'(code) == e.code, "event_code", int'(code), e.code);
                    chk(pressed == e.pressed, "event_pressed", int'(pressed), int'(e.pressed));
                end
                acc_cyc[code] = cyc;
                held = 0;
            end else begin
                held   = 1;
                h_code = code;
                h_pr   = pressed;
            end
        end else begin
            if (held) chk(1'b0, "valid_dropped", 0, 1);
            held = 0;
        end
    end

    task automatic do_scan(input logic [15:0] p);
        int start;
        int n;
        start     = scan_cnt;
        n         = 0;
        phys_next = p;
        while (scan_cnt == start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (scan_cnt == start) chk(1'b0, "scan_timeout", n, 2000);
    endtask

    task automatic scans(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) do_scan(p);
    endtask

    initial begin
        logic [3:0] exp_seq[5];
        logic [3:0] cur;
        int n;
        int t0;
        int a;
        int rst_cyc;

        exp_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        for (int k = 0; k < NK; k++) acc_cyc[k] = -1;
        rst   = 1'b1;
        ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(col == 4'hf, "reset_col", int'(col), 15);
            chk(!valid, "reset_valid", int'(valid), 0);
        end
        chk(code == 4'd0 && !pressed, "reset_code", int'({code, pressed}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Column sequence and 10-cycle column period.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (col == 4'hf && n < 5);
        chk(col == exp_seq[0], "first_col", int'(col), int'(exp_seq[0]));
        for (int i = 0; i < 4; i++) begin
            cur = col;
            n = 0;
            while (col == cur && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk(n == 10, "col_period", n, 10);
            chk(col == exp_seq[i+1], "col_seq", int'(col), int'(exp_seq[i+1]));
        end
        chk(!valid, "idle_no_event", int'(valid), 0);

        // Steady press of key 6 lands on the 3rd scan, SAMPLE of r=2.
        do_scan(16'h0040);
        t0 = bnd_cyc;
        scans(16'h0040, 3);
        chk(acc_cyc[6] == t0 + 98, "press6_time", acc_cyc[6] - t0, 98);
        scans(16'h0000, 4);

        // Bounce: 2 closed, 1 open, then closed.
        a = acc_cyc[6];
        scans(16'h0040, 2);
        do_scan(16'h0000);
        scans(16'h0040, 3);
        chk(acc_cyc[6] == a, "bounce_no_early", acc_cyc[6], a);
        do_scan(16'h0040);
        scans(16'h0000, 4);

        // Two keys in one column with ready tied high: no gap.
        scans(16'h0030, 4);
        chk(acc_cyc[5] == acc_cyc[4] + 1, "b2b_45", acc_cyc[5] - acc_cyc[4], 1);
        scans(16'h0000, 4);

        // Stall with keys 0 and 1.
        rdy_mode = 1;
        scans(16'h0003, 3);
        repeat (30) @(negedge clk);
        chk(valid && code == 4'd0 && pressed, "stall_hold",
            int'({valid, code, pressed}), int'({1'b1, 4'd0, 1'b1}));
        chk(col == 4'b1110, "stall_col", int'(col), 14);
        rdy_mode = 0;
        scans(16'h0003, 2);
        chk(acc_cyc[1] == acc_cyc[0] + 1, "stall_drain", acc_cyc[1] - acc_cyc[0], 1);
        scans(16'h0000, 4);

        // Reset in the middle of a stall; held keys are reported again.
        rdy_mode = 1;
        scans(16'h0003, 3);
        repeat (20) @(negedge clk);
        chk(valid == 1'b1, "stall2_valid", int'(valid), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        rst_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        chk(!valid, "midstall_reset_valid", int'(valid), 0);
        chk(col == 4'hf, "midstall_reset_col", int'(col), 15);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        scans(16'h0003, 4);
        chk(acc_cyc[0] > rst_cyc, "rereport_0", acc_cyc[0], rst_cyc + 1);
        chk(acc_cyc[1] == acc_cyc[0] + 1, "rereport_1", acc_cyc[1] - acc_cyc[0], 1);
        scans(16'h0000, 4);

        // Random key patterns with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) begin
            logic [15:0] p;
            p = 16'($urandom) & 16'($urandom);
            scans(p, $urandom_range(1, 5));
        end

        rdy_mode = 0;
        scans(16'h0000, 5);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(exp_q.size() == 0, "drain_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
